// File: rtl/dp_issue.sv
// ============================================================================
//  Module   : dp_issue
//  Brief    : Issue/decode stage with register file and flag ownership that
//             feeds a data-processing op unit over a one-pulse field bus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_issue #(
    parameter int          NREG     = 16,
    parameter logic [31:0] OP_MASK  = 32'hFFFFFFFF,
    parameter logic [2:0]  FLAG_RST = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_word,
    input  logic        ld_en,
    input  logic [3:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        en_inst,
    output logic [4:0]  instruction,
    output logic        IMM,
    output logic        S,
    output logic [31:0] Rn,
    output logic [31:0] Rm,
    output logic [11:0] imm_operand,
    output logic [4:0]  imm_shift,
    output logic [1:0]  stype,
    output logic        carry_flag,
    output logic        zero_flag,
    output logic        neg_flag,
    input  logic [31:0] Rd_res,
    input  logic        carry_res,
    input  logic        zero_res,
    input  logic        neg_res,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_ILL  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_ready;
    logic        w_en;
    logic        w_done;
    logic        w_ill;

    logic [31:0] r_regs [NREG];
    logic [2:0]  r_flags;

    logic [4:0]  r_opc;
    logic        r_imm;
    logic        r_s;
    logic [3:0]  r_rd_idx;
    logic [31:0] r_rn_val;
    logic [31:0] r_rm_val;
    logic [11:0] r_imm12;
    logic [4:0]  r_shift;
    logic [1:0]  r_stype;

    // Instruction word field decode
    logic [4:0]  w_opc;
    logic        w_imm;
    logic        w_s;
    logic [3:0]  w_rd_idx;
    logic [3:0]  w_rn_idx;
    logic [3:0]  w_rm_idx;
    logic [4:0]  w_shift;
    logic [1:0]  w_stype;
    logic [11:0] w_imm12;
    logic        w_accept;
    logic        w_ld_ok;

    assign w_opc    = instr_word[31:27];
    assign w_imm    = instr_word[26];
    assign w_s      = instr_word[25];
    assign w_rd_idx = instr_word[24:21];
    assign w_rn_idx = instr_word[20:17];
    assign w_rm_idx = instr_word[16:13];
    assign w_shift  = instr_word[12:8];
    assign w_stype  = instr_word[7:6];
    assign w_imm12  = instr_word[11:0];

    assign w_accept = (r_state == S_IDLE) && instr_valid;
    assign w_ld_ok  = (r_state == S_IDLE) && ld_en && ({28'd0, ld_addr} < 32'(NREG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_en    = 1'b0;
        w_done  = 1'b0;
        w_ill   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (instr_valid) begin
                    w_next = OP_MASK[w_opc] ? S_EXEC : S_ILL;
                end
            end
            S_EXEC: begin
                w_en   = 1'b1;
                w_next = S_WB;
            end
            S_WB: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ILL: begin
                w_ill  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are read from the pre-edge regfile, so a same-edge preload
    // to the source index is not visible to this instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opc    <= '0;
            r_imm    <= 1'b0;
            r_s      <= 1'b0;
            r_rd_idx <= '0;
            r_rn_val <= '0;
            r_rm_val <= '0;
            r_imm12  <= '0;
            r_shift  <= '0;
            r_stype  <= '0;
        end else if (w_accept) begin
            r_opc    <= w_opc;
            r_imm    <= w_imm;
            r_s      <= w_s;
            r_rd_idx <= w_rd_idx;
            r_rn_val <= r_regs[w_rn_idx];
            r_rm_val <= w_imm ? 32'd0 : r_regs[w_rm_idx];
            r_imm12  <= w_imm ? w_imm12 : 12'd0;
            r_shift  <= w_imm ? 5'd0 : w_shift;
            r_stype  <= w_imm ? 2'd0 : w_stype;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_WB) begin
            r_regs[r_rd_idx] <= Rd_res;
        end else if (w_ld_ok) begin
            r_regs[ld_addr] <= ld_data;
        end
    end

    // The op unit already passes the old flags through when S=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= FLAG_RST;
        end else if (r_state == S_WB) begin
            r_flags <= {carry_res, zero_res, neg_res};
        end
    end

    assign dbg_data    = ({28'd0, dbg_addr} < 32'(NREG)) ? r_regs[dbg_addr] : 32'd0;
    assign instr_ready = w_ready;
    assign en_inst     = w_en;
    assign done        = w_done;
    assign illegal     = w_ill;
    assign instruction = r_opc;
    assign IMM         = r_imm;
    assign S           = r_s;
    assign Rn          = r_rn_val;
    assign Rm          = r_rm_val;
    assign imm_operand = r_imm12;
    assign imm_shift   = r_shift;
    assign stype       = r_stype;
    assign carry_flag  = r_flags[2];
    assign zero_flag   = r_flags[1];
    assign neg_flag    = r_flags[0];

endmodule

`default_nettype wire

// File: tb/tb_dp_issue.sv
// ============================================================================
//  Module   : tb_dp_issue
//  Brief    : Directed bench for dp_issue with a transaction-level model and
//             a SUB op-unit stand-in driving the result/flag inputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dp_issue;

    localparam logic [31:0] C_MASK  = 32'hFFFFFFFE;
    localparam logic [2:0]  C_FRST  = 3'b000;
    localparam logic [4:0]  C_SUB   = 5'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr_word = '0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        en_inst;
    logic [4:0]  instruction;
    logic        IMM;
    logic        S;
    logic [31:0] Rn;
    logic [31:0] Rm;
    logic [11:0] imm_operand;
    logic [4:0]  imm_shift;
    logic [1:0]  stype;
    logic        carry_flag;
    logic        zero_flag;
    logic        neg_flag;
    logic [31:0] Rd_res = '0;
    logic        carry_res = 1'b0;
    logic        zero_res = 1'b0;
    logic        neg_res = 1'b0;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    dp_issue #(.NREG(16), .OP_MASK(C_MASK), .FLAG_RST(C_FRST)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .en_inst(en_inst), .instruction(instruction), .IMM(IMM), .S(S),
        .Rn(Rn), .Rm(Rm), .imm_operand(imm_operand), .imm_shift(imm_shift), .stype(stype),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .Rd_res(Rd_res), .carry_res(carry_res), .zero_res(zero_res), .neg_res(neg_res),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SUB op-unit stand-in: samples the field bus on the falling edge of EXEC.
    logic [31:0] ou_op2;
    always @(negedge clk) begin
        if (en_inst) begin
            ou_op2 = IMM ? {20'd0, imm_operand} : (Rm << imm_shift);
            Rd_res = Rn - ou_op2;
            if (S) begin
                carry_res = (Rn >= ou_op2);
                zero_res  = (Rd_res == 32'd0);
                neg_res   = Rd_res[31];
            end else begin
                carry_res = carry_flag;
                zero_res  = zero_flag;
                neg_res   = neg_flag;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    logic [31:0] m_regs [16];
    logic [2:0]  m_flags;
    logic [4:0]  m_opc;
    logic        m_imm, m_s, m_legal;
    logic [3:0]  m_rd;
    logic [31:0] m_rn, m_rm, m_res;
    logic [11:0] m_imm12;
    logic [4:0]  m_sh;
    logic [1:0]  m_st;
    logic [2:0]  m_nflags;
    int          m_busy, m_cyc;

    logic        p_acc, p_ld, p_wb;
    logic [4:0]  p_opc;
    logic        p_imm, p_s, p_legal;
    logic [3:0]  p_rd, p_ld_addr;
    logic [31:0] p_rn, p_rm, p_res, p_ld_data;
    logic [11:0] p_imm12;
    logic [4:0]  p_sh;
    logic [1:0]  p_st;
    logic [2:0]  p_nflags;
    int          p_busy, p_cyc;

    always begin
        @(negedge clk);
        p_acc = 1'b0; p_ld = 1'b0; p_wb = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_flags = C_FRST;
            m_opc = '0; m_imm = 1'b0; m_s = 1'b0; m_legal = 1'b0; m_rd = '0;
            m_rn = '0; m_rm = '0; m_res = '0; m_imm12 = '0; m_sh = '0; m_st = '0;
            m_nflags = '0; m_busy = 0; m_cyc = 0; p_busy = 0; p_cyc = 0;
            chk("rst_en_inst", 32'(en_inst), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
        end else begin
            chk("ready", 32'(instr_ready), 32'(m_busy == 0));
            chk("en_inst", 32'(en_inst), 32'(m_busy != 0 && m_legal && m_cyc == 0));
            chk("done", 32'(done), 32'(m_busy != 0 && m_legal && m_cyc == 1));
            chk("illegal", 32'(illegal), 32'(m_busy != 0 && !m_legal));
            chk("instruction", 32'(instruction), 32'(m_opc));
            chk("IMM_S", {30'd0, IMM, S}, {30'd0, m_imm, m_s});
            chk("Rn", Rn, m_rn);
            chk("Rm", Rm, m_rm);
            chk("imm_operand", 32'(imm_operand), 32'(m_imm12));
            chk("shift_stype", {25'd0, imm_shift, stype}, {25'd0, m_sh, m_st});
            chk("flags", {29'd0, carry_flag, zero_flag, neg_flag}, {29'd0, m_flags});
            chk("dbg_data", dbg_data, m_regs[dbg_addr]);
            if (m_busy != 0) begin
                if (m_legal && m_cyc == 1) p_wb = 1'b1;
                p_busy = m_busy - 1;
                p_cyc  = m_cyc + 1;
            end else begin
                if (instr_valid) begin
                    p_acc   = 1'b1;
                    p_opc   = instr_word[31:27];
                    p_imm   = instr_word[26];
                    p_s     = instr_word[25];
                    p_rd    = instr_word[24:21];
                    p_rn    = m_regs[instr_word[20:17]];
                    p_rm    = p_imm ? 32'd0 : m_regs[instr_word[16:13]];
                    p_sh    = p_imm ? 5'd0 : instr_word[12:8];
                    p_st    = p_imm ? 2'd0 : instr_word[7:6];
                    p_imm12 = p_imm ? instr_word[11:0] : 12'd0;
                    p_legal = C_MASK[p_opc];
                    ou_model(p_rn, p_imm ? {20'd0, p_imm12} : (p_rm << p_sh), p_s, m_flags,
                             p_res, p_nflags);
                    p_busy  = p_legal ? 2 : 1;
                    p_cyc   = 0;
                end else begin
                    p_busy = 0;
                    p_cyc  = 0;
                end
                if (ld_en) begin
                    p_ld = 1'b1; p_ld_addr = ld_addr; p_ld_data = ld_data;
                end
            end
        end
        @(posedge clk);
        if (rst_n) begin
            if (p_wb) begin
                m_regs[m_rd] = m_res;
                m_flags      = m_nflags;
            end
            if (p_acc) begin
                m_opc = p_opc; m_imm = p_imm; m_s = p_s; m_rd = p_rd; m_rn = p_rn; m_rm = p_rm;
                m_sh = p_sh; m_st = p_st; m_imm12 = p_imm12; m_legal = p_legal;
                m_res = p_res; m_nflags = p_nflags;
            end
            if (p_ld) m_regs[p_ld_addr] = p_ld_data;
            m_busy = p_busy;
            m_cyc  = p_cyc;
        end
    end

    task automatic ou_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [2:0] fl, output logic [31:0] r, output logic [2:0] nf);
        r  = a - b;
        nf = s ? {a >= b, r == 32'd0, r[31]} : fl;
    endtask

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc_reg(input logic [4:0] opc, input logic s, input logic [3:0] rd,
                                            input logic [3:0] rn, input logic [3:0] rm,
                                            input logic [4:0] sh, input logic [1:0] st);
        return {opc, 1'b0, s, rd, rn, rm, sh, st, 6'd0};
    endfunction

    function automatic logic [31:0] enc_imm(input logic [4:0] opc, input logic s, input logic [3:0] rd,
                                            input logic [3:0] rn, input logic [11:0] imm);
        return {opc, 1'b1, s, rd, rn, 5'd0, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w, input bit keep);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        instr_valid = 1'b1;
        instr_word  = w;
        while (!acc && n < 20) begin
            acc = instr_ready;
            tick();
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        chk(name, dbg_data, exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("init_flags", {29'd0, carry_flag, zero_flag, neg_flag}, 32'd0);

        // Preload and register-form SUB r3 = r1 - r2
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'd10; tick();
        ld_addr = 4'd2; ld_data = 32'd3; tick();
        ld_en = 1'b0;
        issue(enc_reg(C_SUB, 1'b1, 4'd3, 4'd1, 4'd2, 5'd0, 2'd0), 1'b0);
        chk("t2_en", 32'(en_inst), 32'd1);
        chk("t2_Rn", Rn, 32'd10);
        chk("t2_Rm", Rm, 32'd3);
        tick();
        chk("t2_en_off", 32'(en_inst), 32'd0);
        chk("t2_done", 32'(done), 32'd1);
        tick();
        chk_reg("t2_r3", 4'd3, 32'd7);
        chk("t2_flags", {29'd0, carry_flag, zero_flag, neg_flag}, 32'b100);

        // Immediate SUB to zero, then S=0 keeps flags
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'd5; tick();
        ld_en = 1'b0;
        issue(enc_imm(C_SUB, 1'b1, 4'd3, 4'd1, 12'd5), 1'b0);
        chk("t3_imm", 32'(imm_operand), 32'd5);
        repeat (2) tick();
        chk_reg("t3_r3", 4'd3, 32'd0);
        chk("t3_zero", 32'(zero_flag), 32'd1);
        issue(enc_imm(C_SUB, 1'b0, 4'd4, 4'd2, 12'd1), 1'b0);
        repeat (2) tick();
        chk_reg("t3_r4", 4'd4, 32'd2);
        chk("t3_flags_kept", {29'd0, carry_flag, zero_flag, neg_flag}, 32'b110);

        // Illegal opcode 0
        issue(enc_reg(5'd0, 1'b1, 4'd3, 4'd1, 4'd2, 5'd0, 2'd0), 1'b0);
        chk("t4_illegal", 32'(illegal), 32'd1);
        chk("t4_no_en", 32'(en_inst), 32'd0);
        tick();
        chk("t4_ill_off", 32'(illegal), 32'd0);
        chk("t4_ready", 32'(instr_ready), 32'd1);
        chk_reg("t4_r3", 4'd3, 32'd0);
        chk("t4_flags", {29'd0, carry_flag, zero_flag, neg_flag}, 32'b110);

        // Back-to-back with dependent source
        issue(enc_reg(C_SUB, 1'b1, 4'd5, 4'd1, 4'd2, 5'd0, 2'd0), 1'b1);
        issue(enc_imm(C_SUB, 1'b1, 4'd6, 4'd5, 12'd1), 1'b0);
        chk("t5_Rn_fwd", Rn, 32'd2);
        repeat (2) tick();
        chk_reg("t5_r6", 4'd6, 32'd1);

        // Preload during EXEC is ignored; preload with accept keeps old operand
        issue(enc_reg(C_SUB, 1'b0, 4'd7, 4'd1, 4'd2, 5'd0, 2'd0), 1'b0);
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'd99; tick();
        ld_en = 1'b0; tick();
        chk_reg("t6_r1_kept", 4'd1, 32'd5);
        chk_reg("t6_r7", 4'd7, 32'd2);
        ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'd100;
        issue(enc_imm(C_SUB, 1'b0, 4'd8, 4'd2, 12'd0), 1'b0);
        ld_en = 1'b0;
        chk("t6_Rn_old", Rn, 32'd3);
        repeat (2) tick();
        chk_reg("t6_r2_new", 4'd2, 32'd100);
        chk_reg("t6_r8", 4'd8, 32'd3);

        // Asynchronous reset in the middle of EXEC
        issue(enc_reg(C_SUB, 1'b1, 4'd9, 4'd2, 4'd1, 5'd0, 2'd0), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_en", 32'(en_inst), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        chk("t1_flags", {29'd0, carry_flag, zero_flag, neg_flag}, 32'(C_FRST));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) chk_reg("t1_reg_zero", 4'(i), 32'd0);
        repeat (3) tick();
        chk_reg("t1_r9_no_wb", 4'd9, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
